// File: rtl/calibration_pkg.sv
// Shared types and helpers for the LED-to-pixel calibration sequencer.
package calibration_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SHOW    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } cal_state_e;

    typedef enum logic {
        MODE_SEQ = 1'b0,
        MODE_BIN = 1'b1
    } cal_mode_e;

    // RGB565 brightness estimate, halved and clipped to 8 bits
    function automatic logic [7:0] luma8(input logic [15:0] pix);
        logic [9:0] sum_s;
        logic [9:0] half_s;
        sum_s  = ({5'd0, pix[15:11]} << 3) + ({4'd0, pix[10:5]} << 2) + ({5'd0, pix[4:0]} << 3);
        half_s = sum_s >> 1;
        if (half_s > 10'd255) begin
            return 8'hFF;
        end else begin
            return half_s[7:0];
        end
    endfunction

endpackage

// File: rtl/cal_luma_detect.sv
// Two-stage bright-pixel detector: stage 1 computes luma, stage 2 thresholds.
module cal_luma_detect
    import calibration_pkg::*;
#(
    parameter int          PIX_AW      = 16,
    parameter logic [7:0]  LUMA_THRESH = 8'd200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [PIX_AW-1:0] in_addr,
    input  logic [15:0]       in_pix,
    output logic              out_valid,
    output logic [PIX_AW-1:0] out_addr
);

    logic              s1_valid_r;
    logic [PIX_AW-1:0] s1_addr_r;
    logic [7:0]        s1_luma_r;
    logic              s2_valid_r;
    logic [PIX_AW-1:0] s2_addr_r;

    // Pipeline registers; flush kills everything in flight including the current beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_luma_r  <= 8'd0;
            s2_valid_r <= 1'b0;
            s2_addr_r  <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            s1_addr_r  <= in_addr;
            s1_luma_r  <= luma8(in_pix);
            s2_valid_r <= s1_valid_r && (s1_luma_r > LUMA_THRESH);
            s2_addr_r  <= s1_addr_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_addr  = s2_addr_r;

endmodule

// File: rtl/calibration_sequencer.sv
// Lights LEDs step by step, waits for the camera to settle, and records which
// LED(s) light each pixel into an external calibration table.
module calibration_sequencer
    import calibration_pkg::*;
#(
    parameter int         NUM_LEDS      = 50,
    parameter int         NUM_PIXELS    = 64800,
    parameter int         SETTLE_FRAMES = 2,
    parameter logic [7:0] LUMA_THRESH   = 8'd200,
    parameter int         PIX_AW        = $clog2(NUM_PIXELS),
    parameter int         ID_W          = $clog2(NUM_LEDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic              led_req_valid,
    input  logic [ID_W-1:0]   led_req_idx,
    output logic [7:0]        led_r,
    output logic [7:0]        led_g,
    output logic [7:0]        led_b,
    output logic              led_color_valid,
    input  logic              strand_latched,
    input  logic              cam_frame_start,
    input  logic              pix_valid,
    input  logic [PIX_AW-1:0] pix_addr,
    input  logic [15:0]       pix_data,
    output logic              tbl_we,
    output logic [PIX_AW-1:0] tbl_addr,
    output logic [ID_W-1:0]   tbl_wdata,
    output logic [ID_W-1:0]   tbl_wmask,
    output logic [ID_W-1:0]   step_idx,
    output logic              busy,
    output logic              done
);

    localparam int                FC_W       = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam logic [ID_W-1:0]   LAST_SEQ   = ID_W'(NUM_LEDS - 1);
    localparam logic [ID_W-1:0]   LAST_BIN   = ID_W'(ID_W - 1);
    localparam logic [PIX_AW-1:0] LAST_PIX   = PIX_AW'(NUM_PIXELS - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(SETTLE_FRAMES);

    cal_state_e        state_r, state_s;
    cal_mode_e         mode_r, mode_s;
    logic [ID_W-1:0]   step_r, step_s;
    logic [PIX_AW-1:0] clr_cnt_r, clr_cnt_s;
    logic [FC_W-1:0]   frame_cnt_r, frame_cnt_s;
    logic              drain_r, drain_s;
    logic              drain_cnt_r, drain_cnt_s;
    logic [1:0]        ready_r;
    logic              led_valid_r, led_on_r;
    logic              det_valid_s;
    logic [PIX_AW-1:0] det_addr_s;

    logic [ID_W-1:0]   last_step_s;
    logic              clr_we_s;
    logic              det_in_valid_s;
    logic [ID_W-1:0]   cap_data_s, cap_mask_s;
    logic [ID_W:0]     idx_plus_s;
    logic              lit_state_s, lit_s;

    assign last_step_s = (mode_r == MODE_BIN) ? LAST_BIN : LAST_SEQ;

    // Reset-release synchroniser: start is only honoured once this has filled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 2'b00;
        end else begin
            ready_r <= {ready_r[0], 1'b1};
        end
    end

    // FSM and sequencing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_SEQ;
            step_r      <= '0;
            clr_cnt_r   <= '0;
            frame_cnt_r <= '0;
            drain_r     <= 1'b0;
            drain_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            step_r      <= step_s;
            clr_cnt_r   <= clr_cnt_s;
            frame_cnt_r <= frame_cnt_s;
            drain_r     <= drain_s;
            drain_cnt_r <= drain_cnt_s;
        end
    end

    // Next-state logic; CAPTURE also covers the two-cycle pipeline drain
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        step_s      = step_r;
        clr_cnt_s   = clr_cnt_r;
        frame_cnt_s = frame_cnt_r;
        drain_s     = drain_r;
        drain_cnt_s = drain_cnt_r;
        if (abort) begin
            state_s     = ST_IDLE;
            drain_s     = 1'b0;
            drain_cnt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && ready_r[1]) begin
                        state_s   = ST_CLEAR;
                        mode_s    = cal_mode_e'(mode);
                        step_s    = '0;
                        clr_cnt_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_PIX) begin
                        state_s = ST_SHOW;
                    end else begin
                        clr_cnt_s = clr_cnt_r + PIX_AW'(1);
                    end
                end
                ST_SHOW: begin
                    if (strand_latched) begin
                        state_s     = ST_SETTLE;
                        frame_cnt_s = '0;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                ST_SETTLE: begin
                    if (cam_frame_start && (frame_cnt_r == LAST_FRAME)) begin
                        state_s     = ST_CAPTURE;
                        drain_s     = 1'b0;
                        drain_cnt_s = 1'b0;
                    end else if (cam_frame_start) begin
                        frame_cnt_s = frame_cnt_r + FC_W'(1);
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_CAPTURE: begin
                    if (drain_r && drain_cnt_r) begin
                        state_s     = ST_NEXT;
                        drain_s     = 1'b0;
                        drain_cnt_s = 1'b0;
                    end else if (drain_r) begin
                        drain_cnt_s = 1'b1;
                    end else if (cam_frame_start) begin
                        drain_s     = 1'b1;
                        drain_cnt_s = 1'b0;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_NEXT: begin
                    step_s = step_r + ID_W'(1);
                    if (step_r == last_step_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign det_in_valid_s = pix_valid && (state_r == ST_CAPTURE) && !drain_r;

    cal_luma_detect #(
        .PIX_AW      (PIX_AW),
        .LUMA_THRESH (LUMA_THRESH)
    ) u_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (det_in_valid_s),
        .in_addr   (pix_addr),
        .in_pix    (pix_data),
        .out_valid (det_valid_s),
        .out_addr  (det_addr_s)
    );

    // Pipeline is empty whenever CLEAR runs, so the two write sources never collide
    assign clr_we_s   = (state_r == ST_CLEAR);
    assign cap_data_s = (mode_r == MODE_BIN) ? (ID_W'(1) << step_r) : (step_r + ID_W'(1));
    assign cap_mask_s = (mode_r == MODE_BIN) ? (ID_W'(1) << step_r) : '1;
    assign tbl_we     = clr_we_s | det_valid_s;
    assign tbl_addr   = clr_we_s ? clr_cnt_r : det_addr_s;
    assign tbl_wdata  = det_valid_s ? cap_data_s : '0;
    assign tbl_wmask  = det_valid_s ? cap_mask_s : (clr_we_s ? '1 : '0);

    assign step_idx = step_r;
    assign busy     = (state_r != ST_IDLE);
    assign done     = (state_r == ST_DONE);

    // Binary mode codes LED i as i+1 so that no LED is ever dark in every step
    assign lit_state_s = (state_r == ST_SHOW) || (state_r == ST_SETTLE) || (state_r == ST_CAPTURE);
    assign idx_plus_s  = {1'b0, led_req_idx} + (ID_W + 1)'(1);
    assign lit_s       = lit_state_s &&
                         ((mode_r == MODE_BIN) ? (|(idx_plus_s & ((ID_W + 1)'(1) << step_r)))
                                               : (led_req_idx == step_r));

    // One-cycle colour response to the LED driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_valid_r <= 1'b0;
            led_on_r    <= 1'b0;
        end else begin
            led_valid_r <= led_req_valid;
            led_on_r    <= led_req_valid && lit_s;
        end
    end

    assign led_color_valid = led_valid_r;
    assign led_r           = {8{led_on_r}};
    assign led_g           = {8{led_on_r}};
    assign led_b           = {8{led_on_r}};

endmodule

// File: tb/tb_calibration_sequencer.sv
// Randomised scoreboard bench for calibration_sequencer with a behavioural model.
module tb_calibration_sequencer;

    localparam int NL  = 4;
    localparam int NP  = 16;
    localparam int SF  = 2;
    localparam int IDW = 3;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic           led_req_valid = 1'b0;
    logic [IDW-1:0] led_req_idx = '0;
    logic [7:0]     led_r, led_g, led_b;
    logic           led_color_valid;
    logic           strand_latched = 1'b0, cam_frame_start = 1'b0, pix_valid = 1'b0;
    logic [AW-1:0]  pix_addr = '0;
    logic [15:0]    pix_data = 16'd0;
    logic           tbl_we;
    logic [AW-1:0]  tbl_addr;
    logic [IDW-1:0] tbl_wdata, tbl_wmask, step_idx;
    logic           busy, done;

    calibration_sequencer #(
        .NUM_LEDS(NL), .NUM_PIXELS(NP), .SETTLE_FRAMES(SF), .LUMA_THRESH(8'd200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .led_req_valid(led_req_valid), .led_req_idx(led_req_idx),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .led_color_valid(led_color_valid),
        .strand_latched(strand_latched), .cam_frame_start(cam_frame_start),
        .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_wmask(tbl_wmask),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [IDW-1:0] data;
        logic [IDW-1:0] mask;
    } wr_t;

    wr_t            wq[$];
    logic [23:0]    cq[$];
    logic [IDW-1:0] model_tbl[NP];
    logic [IDW-1:0] dut_tbl[NP];
    wr_t            mon_e, mon_a;
    int             npass = 0;
    int             ntot = 0;
    int             done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic bit ref_bright(input logic [15:0] p);
        int l;
        l = (int'(p[15:11]) * 8 + int'(p[10:5]) * 4 + int'(p[4:0]) * 8) / 2;
        if (l > 255) l = 255;
        return l > 200;
    endfunction

    function automatic bit ref_lit(input logic m, input int s, input int i);
        if (m) return (((i + 1) >> s) & 1) == 1;
        return i == s;
    endfunction

    task automatic push_wr(input int a, input logic [IDW-1:0] d, input logic [IDW-1:0] m);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        w.mask = m;
        wq.push_back(w);
        model_tbl[a] = (model_tbl[a] & ~m) | (d & m);
    endtask

    function automatic logic [15:0] rand_pix();
        logic [15:0] p;
        p = 16'($urandom);
        case ($urandom_range(0, 3))
            0: p = 16'($urandom);
            1: begin p[15:13] = 3'b111; p[10:8] = 3'b111; p[4:2] = 3'b111; end
            2: p = 16'hC819;
            default: p = 16'hC839;
        endcase
        return p;
    endfunction

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (tbl_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("tbl_we_unexpected", 32'(tbl_we), 32'd0);
            end else begin
                mon_e = wq.pop_front();
                mon_a.addr = tbl_addr;
                mon_a.data = tbl_wdata;
                mon_a.mask = tbl_wmask;
                chk("tbl_write", 32'(mon_a), 32'(mon_e));
            end
            dut_tbl[tbl_addr] <= (dut_tbl[tbl_addr] & ~tbl_wmask) | (tbl_wdata & tbl_wmask);
        end
        if (led_color_valid === 1'b1) begin
            if (cq.size() == 0) chk("led_valid_unexpected", 32'(led_color_valid), 32'd0);
            else chk("led_color", 32'({led_r, led_g, led_b}), 32'(cq.pop_front()));
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; strand_latched = 1'b0;
        cam_frame_start = 1'b0; pix_valid = 1'b0; led_req_valid = 1'b0;
    endtask

    task automatic begin_run(input logic m);
        cyc();
        mode = m;
        start = 1'b1;
        for (int a = 0; a < NP; a++) push_wr(a, '0, '1);
        repeat (18) begin
            cyc();
            mode = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_cal(input logic m, input bit directed, input int led, input int addr,
                           input logic [IDW-1:0] exp_entry);
        int t;
        int d0;
        int idx;
        logic [IDW-1:0] wd, wm;
        t  = m ? IDW : NL;
        d0 = done_cnt;
        begin_run(m);
        for (int s = 0; s < t; s++) begin
            chk("step_idx", 32'(step_idx), 32'(s));
            wd = m ? IDW'(1 << s) : IDW'(s + 1);
            wm = m ? IDW'(1 << s) : '1;
            repeat (3) begin
                cyc();
                idx = $urandom_range(0, 7);
                led_req_valid = 1'b1;
                led_req_idx = IDW'(idx);
                cq.push_back(ref_lit(m, s, idx) ? 24'hFFFFFF : 24'h000000);
            end
            cyc();
            strand_latched = 1'b1;
            for (int f = 0; f < SF; f++) begin
                cyc();
                cam_frame_start = 1'b1;
                repeat (3) begin
                    cyc();
                    pix_valid = 1'b1;
                    pix_addr = AW'($urandom_range(0, NP - 1));
                    pix_data = 16'hFFFF;
                    start = 1'($urandom_range(0, 1));
                    strand_latched = 1'($urandom_range(0, 1));
                end
            end
            cyc();
            cam_frame_start = 1'b1;
            if (directed) begin
                cyc();
                pix_valid = 1'b1;
                pix_addr = AW'(addr);
                pix_data = ref_lit(m, s, led) ? 16'hFFFF : 16'h0000;
                if (ref_bright(pix_data)) push_wr(addr, wd, wm);
            end else begin
                repeat (6) begin
                    cyc();
                    pix_valid = 1'($urandom_range(0, 1));
                    pix_addr = AW'($urandom_range(0, NP - 1));
                    pix_data = rand_pix();
                    if (pix_valid && ref_bright(pix_data)) push_wr(int'(pix_addr), wd, wm);
                end
            end
            cyc();
            cam_frame_start = 1'b1;
            repeat (5) cyc();
        end
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy_after_run", 32'(busy), 32'd0);
        chk("final_step", 32'(step_idx), 32'(t));
        cyc();
        led_req_valid = 1'b1;
        led_req_idx = IDW'($urandom_range(0, 7));
        cq.push_back(24'h000000);
        repeat (2) cyc();
        for (int a = 0; a < NP; a++) chk("table_entry", 32'(dut_tbl[a]), 32'(model_tbl[a]));
        if (directed) chk("directed_entry", 32'(dut_tbl[addr]), 32'(exp_entry));
    endtask

    initial begin
        int d0;
        for (int a = 0; a < NP; a++) begin
            model_tbl[a] = '0;
            dut_tbl[a]   = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tbl_we", 32'(tbl_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_led_valid", 32'(led_color_valid), 32'd0);
        rst_n = 1'b1;
        repeat (4) cyc();

        run_cal(1'b0, 1'b1, 2, 5, 3'd3);
        run_cal(1'b1, 1'b1, 2, 9, 3'b011);
        run_cal(1'b0, 1'b0, 0, 0, '0);
        run_cal(1'b1, 1'b0, 0, 0, '0);

        // abort with two bright pixels in flight
        d0 = done_cnt;
        begin_run(1'b0);
        cyc();
        strand_latched = 1'b1;
        repeat (SF + 1) begin
            cyc();
            cam_frame_start = 1'b1;
        end
        cyc();
        pix_valid = 1'b1; pix_addr = 4'd3; pix_data = 16'hFFFF;
        cyc();
        pix_valid = 1'b1; pix_addr = 4'd4; pix_data = 16'hFFFF; abort = 1'b1;
        cyc();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tbl_we", 32'(tbl_we), 32'd0);
        repeat (4) cyc();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // reset in the middle of CLEAR
        cyc();
        mode = 1'b0;
        start = 1'b1;
        for (int a = 0; a < NP; a++) push_wr(a, '0, '1);
        repeat (6) cyc();
        rst_n = 1'b0;
        #1;
        chk("midclr_tbl_we", 32'(tbl_we), 32'd0);
        chk("midclr_busy", 32'(busy), 32'd0);
        chk("midclr_addr", 32'(tbl_addr), 32'd0);
        chk("midclr_wmask", 32'(tbl_wmask), 32'd0);
        wq.delete();
        cq.delete();
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        run_cal(1'($urandom_range(0, 1)), 1'b0, 0, 0, '0);

        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("color_queue_empty", 32'(cq.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
